// File: rtl/rr_req_arbiter.sv
// Four-way round-robin arbiter with registered one-hot grant, encoded index and a
// hold limit that revokes a grant after MAX_HOLD consecutive cycles.
module rr_req_arbiter #(
  parameter int unsigned MAX_HOLD = 15,
  parameter int unsigned HOLD_W   = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_req,
  output logic [3:0] o_grant,
  output logic [1:0] o_grant_idx,
  output logic       o_grant_vld,
  output logic       o_timeout
);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e            r_state;
  logic [1:0]        r_ptr;
  logic [1:0]        r_idx;
  logic [3:0]        r_grant;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_timeout;

  logic       w_owner_req;
  logic       w_limit_hit;
  logic       w_release;
  logic [3:0] w_cand_req;
  logic [1:0] w_cand;
  logic       w_win_vld;
  logic [1:0] w_win_idx;

  assign w_owner_req = i_req[r_idx];
  assign w_limit_hit = (r_hold_cnt == HOLD_W'(MAX_HOLD - 1));
  assign w_release   = (r_state == StBusy) && (!w_owner_req || w_limit_hit);
  // The current owner is masked so a re-requesting owner is served last.
  assign w_cand_req  = i_req & ~r_grant;

  // Scan from the farthest offset down so the nearest-to-ptr requester wins.
  always_comb begin
    w_win_vld = 1'b0;
    w_win_idx = 2'd0;
    w_cand    = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      w_cand = r_ptr + 2'(i);
      if (w_cand_req[w_cand]) begin
        w_win_vld = 1'b1;
        w_win_idx = w_cand;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_ptr      <= 2'd0;
      r_idx      <= 2'd0;
      r_grant    <= 4'b0000;
      r_hold_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_win_vld) begin
            r_state    <= StBusy;
            r_grant    <= 4'b0001 << w_win_idx;
            r_idx      <= w_win_idx;
            r_ptr      <= w_win_idx + 2'd1;
            r_hold_cnt <= '0;
          end
        end
        StBusy: begin
          if (w_release) begin
            // Owner still requesting at release means the hold limit revoked it.
            r_timeout <= w_owner_req;
            if (w_win_vld) begin
              r_grant    <= 4'b0001 << w_win_idx;
              r_idx      <= w_win_idx;
              r_ptr      <= w_win_idx + 2'd1;
              r_hold_cnt <= '0;
            end else begin
              r_state    <= StIdle;
              r_grant    <= 4'b0000;
              r_idx      <= 2'd0;
              r_hold_cnt <= '0;
            end
          end else begin
            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_grant     = r_grant;
  assign o_grant_idx = r_idx;
  assign o_grant_vld = (r_state == StBusy);
  assign o_timeout   = r_timeout;

endmodule
